// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: steers the HPS ROM download into region-select/offset writes through a small FIFO
// and holds the game core in reset until the download has drained and settled.
module rom_dl_sequencer #(
    parameter logic [24:0] R1_BASE    = 25'h0C000,
    parameter logic [24:0] R2_BASE    = 25'h10000,
    parameter logic [24:0] R3_BASE    = 25'h18000,
    parameter logic [24:0] ROM_END    = 25'h20000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          SETTLE_CYC = 256
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        DL_ACT,
    input  logic        DL_WR,
    input  logic [24:0] DL_AD,
    input  logic [7:0]  DL_DT,
    output logic        WR_VALID,
    input  logic        WR_READY,
    output logic [3:0]  WR_SEL,
    output logic [16:0] WR_AD,
    output logic [7:0]  WR_DT,
    output logic        CORE_RST,
    output logic        DL_DONE,
    output logic        OVF,
    output logic        RANGE_ERR,
    output logic [24:0] BYTE_CNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE_CYC) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, SETTLE, RUN} state_t;

    state_t        state;
    logic [SW-1:0] settle;
    logic          act_q;
    logic [28:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_after_pop;
    logic [3:0]    sel;
    logic [24:0]   base;
    logic [16:0]   off;
    logic [28:0]   din, head_nxt;
    logic          rise, acc, in_range, full, pop, push, ovf_drop, range_drop;

    assign sel = DL_AD < R1_BASE ? 4'b0001 :
                 DL_AD < R2_BASE ? 4'b0010 :
                 DL_AD < R3_BASE ? 4'b0100 :
                 DL_AD < ROM_END ? 4'b1000 : 4'b0000;
    assign base       = sel[1] ? R1_BASE : sel[2] ? R2_BASE : sel[3] ? R3_BASE : '0;
    assign off        = 17'(DL_AD - base);
    assign in_range   = |sel;
    assign din        = {sel, off, DL_DT};
    assign rise       = DL_ACT & ~act_q;
    assign acc        = DL_WR & DL_ACT;
    assign full       = cnt == CW'(FIFO_DEPTH);
    assign pop        = WR_VALID & WR_READY;
    // a full FIFO still takes a byte when the head leaves in the same cycle
    assign push       = acc & in_range & (~full | pop);
    assign ovf_drop   = acc & in_range & full & ~pop;
    assign range_drop = acc & ~in_range;

    assign cnt_after_pop = cnt - CW'(pop);
    assign cnt_nxt       = cnt_after_pop + CW'(push);
    assign rd_nxt        = rd_ptr + AW'(pop);
    // the output register always holds the entry that will be at the head next cycle
    assign head_nxt      = cnt_nxt == '0 ? '0 : cnt_after_pop == '0 ? din : mem[rd_nxt];

    always_ff @(posedge MCLK)
        if (push) mem[wr_ptr] <= din;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            WR_VALID <= 1'b0;
            {WR_SEL, WR_AD, WR_DT} <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_nxt;
            cnt      <= cnt_nxt;
            WR_VALID <= cnt_nxt != '0;
            {WR_SEL, WR_AD, WR_DT} <= head_nxt;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            act_q     <= 1'b0;
            OVF       <= 1'b0;
            RANGE_ERR <= 1'b0;
            BYTE_CNT  <= '0;
        end else begin
            act_q     <= DL_ACT;
            OVF       <= (OVF & ~rise) | ovf_drop;
            RANGE_ERR <= (RANGE_ERR & ~rise) | range_drop;
            BYTE_CNT  <= rise ? 25'(push) : (push && !(&BYTE_CNT)) ? BYTE_CNT + 25'd1 : BYTE_CNT;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            settle   <= '0;
            CORE_RST <= 1'b1;
            DL_DONE  <= 1'b0;
        end else if (rise) begin
            state    <= LOAD;
            CORE_RST <= 1'b1;
            DL_DONE  <= 1'b0;
        end else begin
            case (state)
                LOAD:   if (!DL_ACT) state <= DRAIN;
                DRAIN:  if (cnt_nxt == '0) begin
                            state  <= SETTLE;
                            settle <= SW'(SETTLE_CYC - 1);
                        end
                SETTLE: if (settle == '0) begin
                            state    <= RUN;
                            CORE_RST <= 1'b0;
                            DL_DONE  <= 1'b1;
                        end else begin
                            settle <= settle - SW'(1);
                        end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: directed scenarios plus random traffic against a queue-based reference model.
module tb_rom_dl_sequencer;
    localparam int          DEPTH   = 4;
    localparam int          SETTLE  = 256;
    localparam logic [24:0] ROM_END = 25'h20000;

    logic        MCLK = 1'b0, RESET_N, DL_ACT, DL_WR, WR_VALID, WR_READY;
    logic [24:0] DL_AD, BYTE_CNT;
    logic [7:0]  DL_DT, WR_DT;
    logic [3:0]  WR_SEL;
    logic [16:0] WR_AD;
    logic        CORE_RST, DL_DONE, OVF, RANGE_ERR;

    always #5 MCLK = ~MCLK;

    rom_dl_sequencer dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .DL_ACT(DL_ACT), .DL_WR(DL_WR), .DL_AD(DL_AD),
        .DL_DT(DL_DT), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_SEL(WR_SEL),
        .WR_AD(WR_AD), .WR_DT(WR_DT), .CORE_RST(CORE_RST), .DL_DONE(DL_DONE),
        .OVF(OVF), .RANGE_ERR(RANGE_ERR), .BYTE_CNT(BYTE_CNT)
    );

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    logic [24:0] bases [4] = '{25'h0, 25'h0C000, 25'h10000, 25'h18000};
    logic [28:0] q [$];
    logic        m_ovf, m_rerr, m_act, last_pop;
    logic [24:0] m_cnt;

    function automatic logic [28:0] entry(input logic [24:0] ad, input logic [7:0] dt);
        for (int i = 3; i >= 0; i--)
            if (ad >= bases[i]) return {4'(1 << i), 17'(ad - bases[i]), dt};
        return '0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_rerr = 0; m_act = 0; m_cnt = '0; last_pop = 0;
    endtask

    task automatic step(input logic act, input logic wr, input logic [24:0] ad,
                        input logic [7:0] dt, input logic rdy);
        logic full;
        DL_ACT = act; DL_WR = wr; DL_AD = ad; DL_DT = dt; WR_READY = rdy;
        @(posedge MCLK); #1;
        full     = q.size() == DEPTH;
        last_pop = q.size() > 0 && rdy;
        if (act && !m_act) begin m_ovf = 0; m_rerr = 0; m_cnt = '0; end
        if (last_pop) void'(q.pop_front());
        if (act && wr) begin
            if (ad >= ROM_END) m_rerr = 1;
            else if (full && !last_pop) m_ovf = 1;
            else begin
                q.push_back(entry(ad, dt));
                if (m_cnt != '1) m_cnt++;
            end
        end
        m_act = act;
        check("wr_valid", WR_VALID, q.size() != 0);
        if (q.size() != 0) check("head", {WR_SEL, WR_AD, WR_DT}, q[0]);
        else check("empty_sel_ad", {WR_SEL, WR_AD}, 0);
        check("ovf", OVF, m_ovf);
        check("range_err", RANGE_ERR, m_rerr);
        check("byte_cnt", BYTE_CNT, m_cnt);
        check("done_vs_rst", DL_DONE, !CORE_RST);
        if (m_act || q.size() != 0) check("rst_busy", CORE_RST, 1);
    endtask

    initial begin
        int n, n_wr;
        bit rel;
        RESET_N = 0; DL_ACT = 0; DL_WR = 0; DL_AD = '0; DL_DT = '0; WR_READY = 0;
        model_reset();
        #12;
        check("rst_valid", WR_VALID, 0);
        check("rst_core_rst", CORE_RST, 1);
        check("rst_done", DL_DONE, 0);
        check("rst_flags", {OVF, RANGE_ERR}, 0);
        check("rst_cnt", BYTE_CNT, 0);
        check("rst_head", {WR_SEL, WR_AD, WR_DT}, 0);
        @(negedge MCLK) RESET_N = 1;

        // one byte per region, free-flowing port
        step(1, 1, 25'h00000, 8'hAA, 1);
        check("t1_first", {WR_SEL, WR_AD, WR_DT}, {4'b0001, 17'd0, 8'hAA});
        step(1, 1, 25'h0C001, 8'h55, 1);
        check("t1_second", {WR_SEL, WR_AD, WR_DT}, {4'b0010, 17'd1, 8'h55});
        step(1, 1, 25'h10002, 8'h11, 1);
        check("t1_third", {WR_SEL, WR_AD, WR_DT}, {4'b0100, 17'd2, 8'h11});
        step(1, 1, 25'h18003, 8'h22, 1);
        check("t1_fourth", {WR_SEL, WR_AD, WR_DT}, {4'b1000, 17'd3, 8'h22});
        step(1, 0, '0, '0, 1);
        check("t1_cnt", BYTE_CNT, 4);

        // strobe without DL_ACT is ignored
        step(0, 1, 25'h20000, 8'h33, 1);
        check("ign_range", RANGE_ERR, 0);
        check("ign_cnt", BYTE_CNT, 4);

        // stalled port overflows after DEPTH bytes
        for (int i = 0; i < 6; i++) step(1, 1, 25'h100 + 25'(i), 8'(i + 1), 0);
        check("t2_ovf", OVF, 1);
        check("t2_cnt", BYTE_CNT, 4);
        check("t2_head_stable", {WR_SEL, WR_AD, WR_DT}, {4'b0001, 17'h100, 8'h01});
        n_wr = 0;
        for (int i = 0; i < 6; i++) begin
            n_wr += int'(WR_VALID);
            step(1, 0, '0, '0, 1);
        end
        check("t2_writes", n_wr, 4);

        // out-of-range byte
        step(1, 1, 25'h20000, 8'h99, 1);
        check("t3_range", RANGE_ERR, 1);
        check("t3_cnt", BYTE_CNT, 4);
        check("t3_no_write", WR_VALID, 0);

        // drain with a toggling port, then settle and release
        for (int i = 0; i < 3; i++) step(1, 1, 25'h1A000 + 25'(i), 8'(8'hC0 + i), 0);
        n = 0; rel = 0;
        for (int k = 0; k < 1000 && !rel; k++) begin
            step(0, 0, '0, '0, k[0]);
            n = last_pop ? 0 : n + 1;
            rel = !CORE_RST;
        end
        check("t4_released", rel, 1);
        check("t4_settle_cycles", n, SETTLE);
        check("t4_done", DL_DONE, 1);

        // re-download from RUN with a byte on the rising edge
        step(1, 1, 25'h00100, 8'h5A, 0);
        check("t5_core_rst", CORE_RST, 1);
        check("t5_done", DL_DONE, 0);
        check("t5_flags", {OVF, RANGE_ERR}, 0);
        check("t5_cnt", BYTE_CNT, 1);

        // async reset mid-load with two entries queued
        step(1, 1, 25'h00200, 8'h01, 0);
        check("t6_queued", BYTE_CNT, 2);
        #2 RESET_N = 0;
        #1;
        check("t6_valid", WR_VALID, 0);
        check("t6_core_rst", CORE_RST, 1);
        check("t6_cnt", BYTE_CNT, 0);
        check("t6_done", DL_DONE, 0);
        model_reset();
        @(negedge MCLK) RESET_N = 1;

        for (int k = 0; k < 3000; k++) begin
            logic act;
            act = ($urandom_range(0, 49) == 0) ? !m_act : m_act;
            if (k == 0) act = 1;
            step(act, 1'($urandom), 25'($urandom_range(0, 32'h23FFF)), 8'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
- Sequences ROM download from the HPS ioctl stream into the core's ROM banks.
- Decodes the linear download address into a one-hot region select plus a region offset.
- Buffers bytes in a small FIFO and presents them on a valid/ready write port, so a slow or shared ROM port can stall.
- Holds the game core in reset until the download completes and a settle period elapses; sits between hps_io and the game core's ROM write interface.

Parameters:
- R1_BASE, 25'h0C000: first byte address of region 1; region 0 spans 0..R1_BASE-1.
- R2_BASE, 25'h10000: first byte address of region 2.
- R3_BASE, 25'h18000: first byte address of region 3.
- ROM_END, 25'h20000: first invalid address; addresses at or above it are range errors.
- FIFO_DEPTH, 4: entries in the byte FIFO; must be a power of 2 and at least 2.
- SETTLE_CYC, 256: MCLK cycles between FIFO empty and core reset release.

Ports:
- MCLK  in  1  system clock.
- RESET_N  in  1  asynchronous reset, active-low.
- DL_ACT  in  1  download active (ioctl_download).
- DL_WR  in  1  byte strobe, one cycle per byte (ioctl_wr).
- DL_AD  in  25  byte address (ioctl_addr).
- DL_DT  in  8  byte data (ioctl_dout).
- WR_VALID  out  1  head FIFO entry present.
- WR_READY  in  1  ROM port accepts the head entry.
- WR_SEL  out  4  one-hot region select of the head entry.
- WR_AD  out  17  offset within the region (low 17 bits of DL_AD minus region base).
- WR_DT  out  8  data of the head entry.
- CORE_RST  out  1  active-high reset to the game core.
- DL_DONE  out  1  download completed and core released.
- OVF  out  1  sticky: a byte was dropped because the FIFO was full.
- RANGE_ERR  out  1  sticky: a byte was dropped because its address was at or above ROM_END.
- BYTE_CNT  out  25  count of accepted bytes in the current download; saturates at all-ones.

Behaviour:
- Reset (RESET_N=0, async): state IDLE, FIFO empty, WR_VALID=0, WR_SEL=0, WR_AD=0, WR_DT=0, CORE_RST=1, DL_DONE=0, OVF=0, RANGE_ERR=0, BYTE_CNT=0, settle counter 0, DL_ACT edge register 0.
- States:
  - IDLE: CORE_RST=1 (no ROM loaded yet).
  - LOAD: CORE_RST=1.
  - DRAIN: CORE_RST=1.
  - SETTLE: CORE_RST=1.
  - RUN: CORE_RST=0, DL_DONE=1.
- Transitions:
  - Rising DL_ACT (DL_ACT=1, registered previous=0), from any state -> LOAD. Same edge clears OVF, RANGE_ERR, BYTE_CNT and DL_DONE. The FIFO is not flushed.
  - LOAD, DL_ACT=0 -> DRAIN.
  - DRAIN, FIFO empty -> SETTLE, counter loaded with SETTLE_CYC-1.
  - SETTLE, counter decrements each cycle; at 0 -> RUN.
  - DL_ACT=1 during SETTLE or RUN is a rising edge and returns to LOAD.
- Accept rule: DL_WR=1 and DL_ACT=1. DL_WR with DL_ACT=0 is ignored and sets no flags.
- Byte in the same cycle as the rising edge: accepted; BYTE_CNT ends at 1, not 0; flags are cleared, then set if that byte errs.
- Decode, combinational on DL_AD:
  - DL_AD < R1_BASE -> sel 0001, offset DL_AD.
  - DL_AD < R2_BASE -> sel 0010, offset DL_AD-R1_BASE.
  - DL_AD < R3_BASE -> sel 0100, offset DL_AD-R2_BASE.
  - DL_AD < ROM_END -> sel 1000, offset DL_AD-R3_BASE.
  - Otherwise: dropped, RANGE_ERR=1, BYTE_CNT unchanged.
  - Offset is truncated to 17 bits.
- Push: an accepted in-range byte is pushed as {sel, offset, data}; BYTE_CNT increments, saturating.
- Full FIFO: if the FIFO is full and no pop occurs this cycle, the byte is dropped, OVF=1, BYTE_CNT unchanged. If full with a simultaneous pop, the push succeeds.
- Pop: WR_VALID=1 whenever the FIFO is non-empty. Pop when WR_VALID & WR_READY. WR_SEL, WR_AD and WR_DT are registered outputs of the head entry and hold stable while WR_VALID=1 and WR_READY=0.
- WR_READY is ignored while WR_VALID=0.
- Latency: byte accepted at cycle n into an empty FIFO -> WR_VALID=1 with that byte at cycle n+1.
- Throughput: one byte per cycle with WR_READY held high.
- WR_SEL and WR_AD return to 0 when the FIFO empties.
- Simultaneous push and pop on a non-empty FIFO: occupancy unchanged, order preserved.
- DL_ACT falling with entries queued: entries keep draining in DRAIN; CORE_RST stays 1 until the FIFO is empty plus SETTLE_CYC cycles.
- Async reset mid-download: everything returns to reset values; queued bytes are lost.
- CORE_RST and DL_DONE are registered; CORE_RST falls in the same cycle DL_DONE rises.

Test Plan:
1. Reset, then DL_ACT=1, bytes at 0x00000 (0xAA), 0x0C001 (0x55), 0x10002 (0x11), 0x18003 (0x22) with WR_READY=1 -> four writes in order: sel 0001/ad 0, 0010/ad 1, 0100/ad 2, 1000/ad 3; BYTE_CNT=4.
2. WR_READY=0; push 6 back-to-back bytes -> first 4 queued, OVF=1, BYTE_CNT=4, WR_* stable. Then WR_READY=1 -> exactly 4 writes in order.
3. Byte at DL_AD=0x20000 -> no write, RANGE_ERR=1, BYTE_CNT unchanged. DL_WR with DL_ACT=0 -> ignored, no flags.
4. Drop DL_ACT with 3 entries queued and WR_READY toggling -> DRAIN until empty, then CORE_RST falls and DL_DONE rises exactly 256 cycles after the last pop.
5. From RUN, assert DL_ACT together with DL_WR -> CORE_RST=1 and DL_DONE=0 next cycle, OVF and RANGE_ERR cleared, BYTE_CNT=1.
6. Pull RESET_N low mid-LOAD with 2 entries queued -> immediate WR_VALID=0, CORE_RST=1, BYTE_CNT=0, state IDLE.
